// File: rtl/io_input_monitor.sv
// Discrete input bank conditioner: 2-flop synchroniser, shared-tick debounce,
// sticky rise/fall event flags with write-1-to-clear and a level interrupt.
module io_input_monitor #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DIV_W = 16,
   parameter int unsigned STB_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pad_y,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [STB_W-1:0] cfg_stable,
   input  logic [WIDTH-1:0] rise_en,
   input  logic [WIDTH-1:0] fall_en,
   input  logic             clr_stb,
   input  logic [WIDTH-1:0] clr_mask,
   output logic [WIDTH-1:0] state_out,
   output logic [WIDTH-1:0] event_out,
   output logic             valid,
   output logic             irq
);

   localparam logic [1:0] PH_WAIT0 = 2'd0;
   localparam logic [1:0] PH_WAIT1 = 2'd1;
   localparam logic [1:0] PH_PRIME = 2'd2;
   localparam logic [1:0] PH_RUN   = 2'd3;

   logic [1:0]       phase;
   logic [WIDTH-1:0] sync_a;
   logic [WIDTH-1:0] sync;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [STB_W-1:0] stb_cnt [WIDTH];
   logic [WIDTH-1:0] accept;
   logic [WIDTH-1:0] event_set;
   logic [WIDTH-1:0] event_clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync   <= '0;
      end else begin
         sync_a <= pad_y;
         sync   <= sync_a;
      end
   end

   // Two settling edges, then the third edge primes state_out from sync.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= PH_WAIT0;
      end else begin
         case (phase)
            PH_WAIT0: phase <= PH_WAIT1;
            PH_WAIT1: phase <= PH_PRIME;
            default:  phase <= PH_RUN;
         endcase
      end
   end

   assign valid = (phase == PH_RUN);
   // >= lets a lowered cfg_div wrap on the next cycle instead of running to overflow.
   assign tick  = valid && (div_cnt >= cfg_div);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (phase == PH_PRIME) begin
         div_cnt <= '0;
      end else if (valid) begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
   end

   always_comb begin
      accept = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         accept[i] = tick && (sync[i] != state_out[i]) && (stb_cnt[i] >= cfg_stable);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < WIDTH; i++) stb_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!valid || sync[i] == state_out[i]) begin
               stb_cnt[i] <= '0;
            end else if (tick) begin
               if (stb_cnt[i] >= cfg_stable) stb_cnt[i] <= '0;
               else if (stb_cnt[i] != '1)    stb_cnt[i] <= stb_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_out <= '0;
      end else if (phase == PH_PRIME) begin
         state_out <= sync;
      end else if (valid) begin
         state_out <= state_out ^ accept;
      end
   end

   // Accepted bits flip to sync, so sync gives the new level for edge direction.
   assign event_set = accept & ((sync & rise_en) | (~sync & fall_en));
   assign event_clr = clr_stb ? clr_mask : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         event_out <= '0;
         irq       <= 1'b0;
      end else begin
         event_out <= (event_out & ~event_clr) | event_set;
         irq       <= |event_out;
      end
   end

endmodule
